fractal_sync_barrier_rf: RTL and testbench

- Multi-port barrier register file for a fractal sync node.
- Accepts barrier arrivals tagged with a barrier ID and a source-destination mask (sd_e: east/north, west/south, both).
- Tracks partial arrivals in a small associative table and issues one completion per barrier once both sides have arrived.
- Generalises the single-pair node to N_PORTS request channels with configurable table depth and ID width; sits between node request ports and the upward/response path.

---
 rtl/fractal_sync_pkg.sv | 16 +
 rtl/fractal_sync_rr_arb.sv | 59 +++++
 rtl/fractal_sync_barrier_rf.sv | 196 +++++++++++++++++++
 tb/tb_fractal_sync_barrier_rf.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// Shared fractal sync definitions: source/destination side mask and defaults.
package fractal_sync_pkg;

    localparam int unsigned SD_WIDTH = 2;

    // Side mask carried by every barrier arrival.
    typedef enum logic [SD_WIDTH-1:0] {
        SD_NONE       = 2'b00,
        SD_EAST_NORTH = 2'b01,
        SD_WEST_SOUTH = 2'b10,
        SD_BOTH       = 2'b11
    } sd_e;

    localparam int unsigned DEFAULT_BARRIER_RF_DEPTH = 4;

endpackage

// File: rtl/fractal_sync_rr_arb.sv
// N-input round-robin arbiter. The search starts at the pointer; the pointer
// moves past the granted input only when the advance strobe is high.
module fractal_sync_rr_arb #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    eligible,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grant_idx
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic            found;
    int unsigned     cand;

    // First eligible input at or after the pointer, wrapping around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && eligible[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IdxW'(cand);
            end
        end
    end

    // Next pointer is one past the winner; held when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            if (32'(grant_idx) + 1 >= N) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fractal_sync_barrier_rf.sv
// Multi-port barrier register file for a fractal sync node. Partial arrivals
// are kept in a small associative table keyed by barrier ID; one completion is
// issued per barrier once both sides have arrived.
// Optional: define FRACTAL_SYNC_BARRIER_RF_STATS_EN for occupancy_o and a
// high-water register.
module fractal_sync_barrier_rf
    import fractal_sync_pkg::*;
#(
    parameter int unsigned N_PORTS  = 2,
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned DEPTH    = DEFAULT_BARRIER_RF_DEPTH,
    parameter int unsigned SD_W     = SD_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_PORTS-1:0]           req_valid_i,
    output logic [N_PORTS-1:0]           req_ready_o,
    input  logic [N_PORTS*ID_WIDTH-1:0]  req_id_i,
    input  logic [N_PORTS*SD_W-1:0]      req_sd_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [ID_WIDTH-1:0]          rsp_id_o,
    output logic                         err_o
`ifdef FRACTAL_SYNC_BARRIER_RF_STATS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
`endif
);

    localparam int unsigned EntW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PortW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    localparam logic [SD_W-1:0] SdNone = SD_W'(SD_NONE);
    localparam logic [SD_W-1:0] SdBoth = SD_W'(SD_BOTH);

    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
        logic [SD_W-1:0]     sd;
    } entry_t;

    entry_t [DEPTH-1:0]              tbl_q, tbl_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0]             rsp_id_q, rsp_id_d;
    logic                            err_q, err_d;

    logic                            slot_free;
    logic                            free_exists;
    logic [EntW-1:0]                 free_idx;
    logic [N_PORTS-1:0]              hit;
    logic [N_PORTS-1:0][EntW-1:0]    hit_idx;
    logic [N_PORTS-1:0]              eligible;
    logic [N_PORTS-1:0]              grant;
    logic [PortW-1:0]                grant_idx;
    logic                            any_grant;
    logic [ID_WIDTH-1:0]             sel_id;
    logic [SD_W-1:0]                 sel_sd;
    logic                            sel_hit;
    logic [EntW-1:0]                 sel_idx;

    // Output slot can take a new completion this cycle.
    assign slot_free = !rsp_valid_q || rsp_ready_i;

    // Lowest-index free entry.
    always_comb begin
        free_exists = 1'b0;
        free_idx    = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            if (!free_exists && !tbl_q[e].valid) begin
                free_exists = 1'b1;
                free_idx    = EntW'(e);
            end
        end
    end

    // Per-port ID lookup and eligibility; ready is forced low while in reset.
    always_comb begin
        hit      = '0;
        hit_idx  = '0;
        eligible = '0;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (!hit[p] && tbl_q[e].valid &&
                    tbl_q[e].id == req_id_i[p*ID_WIDTH +: ID_WIDTH]) begin
                    hit[p]     = 1'b1;
                    hit_idx[p] = EntW'(e);
                end
            end
            eligible[p] = rst_ni && req_valid_i[p] && slot_free &&
                          (req_sd_i[p*SD_W +: SD_W] == SdBoth ||
                           req_sd_i[p*SD_W +: SD_W] == SdNone ||
                           hit[p] || free_exists);
        end
    end

    fractal_sync_rr_arb #(
        .N    (N_PORTS),
        .IdxW (PortW)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .eligible  (eligible),
        .advance   (any_grant),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign any_grant   = |eligible;
    assign req_ready_o = grant;
    assign sel_id      = req_id_i[grant_idx*ID_WIDTH +: ID_WIDTH];
    assign sel_sd      = req_sd_i[grant_idx*SD_W +: SD_W];
    assign sel_hit     = hit[grant_idx];
    assign sel_idx     = hit_idx[grant_idx];

    // Apply the accepted arrival to the table and the response/error outputs.
    always_comb begin
        tbl_d       = tbl_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready_i;
        rsp_id_d    = rsp_id_q;
        err_d       = 1'b0;
        if (any_grant) begin
            if (sel_sd == SdNone) begin
                err_d = 1'b1;
            end else if (sel_sd == SdBoth) begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = sel_id;
            end else if (sel_hit) begin
                if ((tbl_q[sel_idx].sd & sel_sd) == '0) begin
                    // Other side already waiting: barrier complete.
                    tbl_d[sel_idx] = '0;
                    rsp_valid_d    = 1'b1;
                    rsp_id_d       = sel_id;
                end else begin
                    // Same side arrived twice.
                    err_d = 1'b1;
                end
            end else begin
                tbl_d[free_idx].valid = 1'b1;
                tbl_d[free_idx].id    = sel_id;
                tbl_d[free_idx].sd    = sel_sd;
            end
        end
    end

    // Table and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tbl_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            tbl_q       <= tbl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            err_q       <= err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign err_o       = err_q;

`ifdef FRACTAL_SYNC_BARRIER_RF_STATS_EN
    localparam int unsigned OccW = $clog2(DEPTH + 1);

    logic [OccW-1:0] occ_q, occ_d, hwm_q;

    // Count of entries that will be valid after this edge.
    always_comb begin
        occ_d = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            occ_d = occ_d + OccW'(tbl_d[e].valid);
        end
    end

    // Occupancy and high-water registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q <= '0;
            hwm_q <= '0;
        end else begin
            occ_q <= occ_d;
            if (occ_q > hwm_q && 32'(hwm_q) < DEPTH) begin
                hwm_q <= occ_q;
            end
        end
    end

    assign occupancy_o = occ_q;

    occ_in_range_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        32'(occ_q) <= DEPTH && 32'(hwm_q) <= DEPTH);
`endif

endmodule

// File: tb/tb_fractal_sync_barrier_rf.sv
// Directed bench for fractal_sync_barrier_rf (N_PORTS=2, ID_WIDTH=4, DEPTH=4).
module tb_fractal_sync_barrier_rf;

    logic       clk;
    logic       rst_ni;
    logic [1:0] req_valid_i;
    logic [1:0] req_ready_o;
    logic [7:0] req_id_i;
    logic [3:0] req_sd_i;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic [3:0] rsp_id_o;
    logic       err_o;

    int n_checks = 0;
    int n_pass   = 0;

    fractal_sync_barrier_rf #(
        .N_PORTS  (2),
        .ID_WIDTH (4),
        .DEPTH    (4),
        .SD_W     (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_id_i    (req_id_i),
        .req_sd_i    (req_sd_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [3:0] id0, input logic [1:0] sd0,
                         input logic v1, input logic [3:0] id1, input logic [1:0] sd1);
        req_valid_i = {v1, v0};
        req_id_i    = {id1, id0};
        req_sd_i    = {sd1, sd0};
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 2'b00, 1'b0, 4'd0, 2'b00);
    endtask

    initial begin
        rst_ni      = 1'b0;
        rsp_ready_i = 1'b1;
        idle();
        #3;
        check_eq("rst_rsp_valid", 32'(rsp_valid_o), 0);
        check_eq("rst_rsp_id", 32'(rsp_id_o), 0);
        check_eq("rst_err", 32'(err_o), 0);
        check_eq("rst_ready", 32'(req_ready_o), 0);
        step();
        step();
        rst_ni = 1'b1;

        // Two-sided barrier id=3 split across ports.
        drive(1'b1, 4'd3, 2'b01, 1'b0, 4'd0, 2'b00);
        #1 check_eq("t1_ready_p0", 32'(req_ready_o), 32'b01);
        step();
        check_eq("t1_no_rsp", 32'(rsp_valid_o), 0);
        drive(1'b0, 4'd0, 2'b00, 1'b1, 4'd3, 2'b10);
        #1 check_eq("t1_ready_p1", 32'(req_ready_o), 32'b10);
        step();
        check_eq("t1_rsp_valid", 32'(rsp_valid_o), 1);
        check_eq("t1_rsp_id", 32'(rsp_id_o), 3);
        check_eq("t1_err", 32'(err_o), 0);
        idle();
        step();
        check_eq("t1_rsp_clear", 32'(rsp_valid_o), 0);

        // SD_BOTH completes immediately.
        drive(1'b1, 4'd5, 2'b11, 1'b0, 4'd0, 2'b00);
        #1 check_eq("t2_ready", 32'(req_ready_o), 32'b01);
        step();
        check_eq("t2_rsp_valid", 32'(rsp_valid_o), 1);
        check_eq("t2_rsp_id", 32'(rsp_id_o), 5);
        idle();
        step();

        // Fill the table with ids 0..3, east side.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i), 2'b01, 1'b0, 4'd0, 2'b00);
            #1 check_eq("t3_fill_ready", 32'(req_ready_o), 32'b01);
            step();
            check_eq("t3_fill_no_rsp", 32'(rsp_valid_o), 0);
        end
        drive(1'b1, 4'd7, 2'b01, 1'b0, 4'd0, 2'b00);
        #1 check_eq("t3_full_stall", 32'(req_ready_o), 0);
        step();
        check_eq("t3_full_stall2", 32'(req_ready_o), 0);
        drive(1'b1, 4'd7, 2'b01, 1'b1, 4'd2, 2'b10);
        #1 check_eq("t3_match_when_full", 32'(req_ready_o), 32'b10);
        step();
        check_eq("t3_cpl_valid", 32'(rsp_valid_o), 1);
        check_eq("t3_cpl_id", 32'(rsp_id_o), 2);
        drive(1'b1, 4'd7, 2'b01, 1'b0, 4'd0, 2'b00);
        #1 check_eq("t3_alloc_resumes", 32'(req_ready_o), 32'b01);
        step();
        check_eq("t3_alloc_no_rsp", 32'(rsp_valid_o), 0);
        // Close id 7 and the remaining ids from port 1.
        drive(1'b0, 4'd0, 2'b00, 1'b1, 4'd7, 2'b10);
        #1 check_eq("t3_close7_ready", 32'(req_ready_o), 32'b10);
        step();
        check_eq("t3_close7_id", 32'(rsp_id_o), 7);
        for (int i = 0; i < 4; i++) begin
            if (i != 2) begin
                drive(1'b0, 4'd0, 2'b00, 1'b1, 4'(i), 2'b10);
                step();
                check_eq("t3_close_valid", 32'(rsp_valid_o), 1);
                check_eq("t3_close_id", 32'(rsp_id_o), 32'(i));
            end
        end
        idle();
        step();

        // Same side twice is a protocol error.
        drive(1'b1, 4'd4, 2'b01, 1'b0, 4'd0, 2'b00);
        step();
        check_eq("t4_first_err", 32'(err_o), 0);
        check_eq("t4_first_rsp", 32'(rsp_valid_o), 0);
        #1 check_eq("t4_dup_ready", 32'(req_ready_o), 32'b01);
        step();
        check_eq("t4_dup_err", 32'(err_o), 1);
        check_eq("t4_dup_no_rsp", 32'(rsp_valid_o), 0);
        idle();
        step();
        check_eq("t4_err_pulse", 32'(err_o), 0);
        drive(1'b0, 4'd0, 2'b00, 1'b1, 4'd4, 2'b10);
        #1 check_eq("t4_close_ready", 32'(req_ready_o), 32'b10);
        step();
        check_eq("t4_close_valid", 32'(rsp_valid_o), 1);
        check_eq("t4_close_id", 32'(rsp_id_o), 4);

        // Both ports SD_BOTH every cycle: grants alternate 0,1,0,1.
        drive(1'b1, 4'd10, 2'b11, 1'b1, 4'd11, 2'b11);
        for (int k = 0; k < 4; k++) begin
            #1 check_eq("t5_rr_grant", 32'(req_ready_o), (k % 2 == 0) ? 32'b01 : 32'b10);
            step();
            check_eq("t5_rr_valid", 32'(rsp_valid_o), 1);
            check_eq("t5_rr_id", 32'(rsp_id_o), (k % 2 == 0) ? 32'd10 : 32'd11);
        end
        rsp_ready_i = 1'b0;
        #1 check_eq("t5_stall_ready", 32'(req_ready_o), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("t5_stall_ready_c", 32'(req_ready_o), 0);
            check_eq("t5_stall_valid", 32'(rsp_valid_o), 1);
            check_eq("t5_stall_id", 32'(rsp_id_o), 11);
        end
        idle();
        rsp_ready_i = 1'b1;
        step();
        check_eq("t5_drain", 32'(rsp_valid_o), 0);

        // Reset with partial entries and a pending response.
        drive(1'b1, 4'd12, 2'b01, 1'b0, 4'd0, 2'b00);
        step();
        drive(1'b1, 4'd13, 2'b01, 1'b0, 4'd0, 2'b00);
        step();
        drive(1'b1, 4'd14, 2'b11, 1'b0, 4'd0, 2'b00);
        step();
        rsp_ready_i = 1'b0;
        check_eq("t6_pending_valid", 32'(rsp_valid_o), 1);
        check_eq("t6_pending_id", 32'(rsp_id_o), 14);
        drive(1'b1, 4'd12, 2'b10, 1'b0, 4'd0, 2'b00);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(rsp_valid_o), 0);
        check_eq("t6_rst_id", 32'(rsp_id_o), 0);
        check_eq("t6_rst_err", 32'(err_o), 0);
        check_eq("t6_rst_ready", 32'(req_ready_o), 0);
        step();
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        #1 check_eq("t6_fresh_ready", 32'(req_ready_o), 32'b01);
        step();
        check_eq("t6_fresh_alloc", 32'(rsp_valid_o), 0);
        drive(1'b1, 4'd12, 2'b01, 1'b0, 4'd0, 2'b00);
        #1 check_eq("t6_close_ready", 32'(req_ready_o), 32'b01);
        step();
        check_eq("t6_close_valid", 32'(rsp_valid_o), 1);
        check_eq("t6_close_id", 32'(rsp_id_o), 12);

        // Empty side mask is consumed as an error.
        drive(1'b0, 4'd0, 2'b00, 1'b1, 4'd9, 2'b00);
        #1 check_eq("t7_none_ready", 32'(req_ready_o), 32'b10);
        step();
        check_eq("t7_none_err", 32'(err_o), 1);
        check_eq("t7_none_no_rsp", 32'(rsp_valid_o), 0);
        idle();
        step();
        check_eq("t7_err_clear", 32'(err_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
